// File: rtl/us_pkg.sv
// rtl/us_pkg.sv - shared state encoding, timing defaults and distance scaling for the ping scheduler
package us_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TRIG,
    WAIT_ECHO,
    ECHO,
    GAP
  } us_state_e;

  localparam int unsigned TRIG_TICKS_DEF   = 500;
  localparam int unsigned ECHO_TIMEOUT_DEF = 600000;
  localparam int unsigned ECHO_MAX_DEF     = 600000;
  localparam int unsigned GAP_TICKS_DEF    = 3000000;

  localparam logic [15:0] NO_ECHO_MM = 16'hFFFF;

  // mm = ticks * 7 / 2048 approximates the round-trip sound speed at a 50 MHz tick
  localparam int unsigned DIST_MUL   = 7;
  localparam int unsigned DIST_SHIFT = 11;

  function automatic logic [15:0] ticks_to_mm(input logic [31:0] ticks);
    logic [31:0] prod;
    prod = ticks * 32'(DIST_MUL);
    return 16'(prod >> DIST_SHIFT);
  endfunction

endpackage

// File: rtl/us_rr_pick.sv
// rtl/us_rr_pick.sv - cyclic search for the next masked-in channel after last_id
module us_rr_pick #(
  parameter int N_SENSORS = 4
) (
  input  logic [N_SENSORS-1:0]         mask,
  input  logic [$clog2(N_SENSORS)-1:0] last_id,
  output logic [$clog2(N_SENSORS)-1:0] next_id,
  output logic                         any
);

  localparam int IDW = $clog2(N_SENSORS);

  int unsigned          idx;
  logic [IDW-1:0]       sel;

  // Scan from the farthest candidate to the nearest so the closest hit after last_id wins.
  always_comb begin
    next_id = '0;
    idx     = 0;
    sel     = '0;
    for (int k = N_SENSORS; k >= 1; k--) begin
      idx = (int'(last_id) + k) % N_SENSORS;
      sel = IDW'(idx);
      if (mask[sel]) begin
        next_id = sel;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// rtl/ultrasonic_scheduler.sv - round-robin HC-SR04 ping scheduler with distance store and near flags
module ultrasonic_scheduler
  import us_pkg::*;
#(
  parameter int unsigned N_SENSORS    = 4,
  parameter int unsigned TRIG_TICKS   = TRIG_TICKS_DEF,
  parameter int unsigned ECHO_TIMEOUT = ECHO_TIMEOUT_DEF,
  parameter int unsigned ECHO_MAX     = ECHO_MAX_DEF,
  parameter int unsigned GAP_TICKS    = GAP_TICKS_DEF,
  parameter int unsigned NEAR_MM      = 70
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_SENSORS-1:0]         sensor_mask,
  input  logic [N_SENSORS-1:0]         echo_rx,
  output logic [N_SENSORS-1:0]         trig,
  output logic                         busy,
  output logic                         sample_valid,
  output logic [$clog2(N_SENSORS)-1:0] sample_id,
  output logic [15:0]                  sample_dist,
  input  logic [$clog2(N_SENSORS)-1:0] rd_sel,
  output logic [15:0]                  rd_dist,
  output logic [N_SENSORS-1:0]         near
);

  localparam int IDW = $clog2(N_SENSORS);

  us_state_e            state_q, state_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          echo_ticks_q, echo_ticks_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [IDW-1:0]       sample_id_q, sample_id_d;
  logic [15:0]          sample_dist_q, sample_dist_d;
  logic [N_SENSORS-1:0] near_q, near_d;
  logic [15:0]          ram_q [N_SENSORS];
  logic [15:0]          ram_d [N_SENSORS];
  logic [N_SENSORS-1:0] echo_s1_q, echo_s2_q, echo_prev_q;

  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 echo_cur;
  logic                 echo_rise;
  logic                 done;
  logic [15:0]          done_dist;

  us_rr_pick #(
    .N_SENSORS (N_SENSORS)
  ) u_pick (
    .mask    (sensor_mask),
    .last_id (last_id_q),
    .next_id (pick_id),
    .any     (pick_any)
  );

  // echo_prev_q lets an echo that is already high on WAIT_ECHO entry be ignored until it re-rises.
  assign echo_cur  = echo_s2_q[cur_id_q];
  assign echo_rise = echo_cur & ~echo_prev_q[cur_id_q];

  always_comb begin
    state_d        = state_q;
    cur_id_d       = cur_id_q;
    last_id_d      = last_id_q;
    cnt_d          = cnt_q;
    echo_ticks_d   = echo_ticks_q;
    sample_valid_d = 1'b0;
    sample_id_d    = sample_id_q;
    sample_dist_d  = sample_dist_q;
    near_d         = near_q;
    ram_d          = ram_q;
    done           = 1'b0;
    done_dist      = NO_ECHO_MM;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && (|sensor_mask)) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d = '0;
        if (pick_any) begin
          cur_id_d = pick_id;
          state_d  = TRIG;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        if (cnt_q == 32'(TRIG_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_ECHO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          echo_ticks_d = 32'd1;
          cnt_d        = '0;
          state_d      = ECHO;
        end else if (cnt_q == 32'(ECHO_TIMEOUT - 1)) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ECHO: begin
        if (!echo_cur) begin
          done      = 1'b1;
          done_dist = ticks_to_mm(echo_ticks_q);
        end else if ((echo_ticks_q + 32'd1) >= 32'(ECHO_MAX)) begin
          done = 1'b1;
        end else begin
          echo_ticks_d = echo_ticks_q + 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == 32'(GAP_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = enable ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done) begin
      sample_valid_d   = 1'b1;
      sample_id_d      = cur_id_q;
      sample_dist_d    = done_dist;
      ram_d[cur_id_q]  = done_dist;
      near_d[cur_id_q] = (done_dist != NO_ECHO_MM) && (done_dist < 16'(NEAR_MM));
      last_id_d        = cur_id_q;
      cnt_d            = '0;
      echo_ticks_d     = '0;
      state_d          = GAP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cur_id_q       <= '0;
      last_id_q      <= IDW'(N_SENSORS - 1);
      cnt_q          <= '0;
      echo_ticks_q   <= '0;
      sample_valid_q <= 1'b0;
      sample_id_q    <= '0;
      sample_dist_q  <= '0;
      near_q         <= '0;
      echo_s1_q      <= '0;
      echo_s2_q      <= '0;
      echo_prev_q    <= '0;
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        ram_q[i] <= NO_ECHO_MM;
      end
    end else begin
      state_q        <= state_d;
      cur_id_q       <= cur_id_d;
      last_id_q      <= last_id_d;
      cnt_q          <= cnt_d;
      echo_ticks_q   <= echo_ticks_d;
      sample_valid_q <= sample_valid_d;
      sample_id_q    <= sample_id_d;
      sample_dist_q  <= sample_dist_d;
      near_q         <= near_d;
      echo_s1_q      <= echo_rx;
      echo_s2_q      <= echo_s1_q;
      echo_prev_q    <= echo_s2_q;
      ram_q          <= ram_d;
    end
  end

  // Trigger is decoded from registered state so an asynchronous reset drops it immediately.
  always_comb begin
    trig = '0;
    if (state_q == TRIG) begin
      trig[cur_id_q] = 1'b1;
    end
  end

  assign busy         = (state_q != IDLE);
  assign sample_valid = sample_valid_q;
  assign sample_id    = sample_id_q;
  assign sample_dist  = sample_dist_q;
  assign rd_dist      = ram_q[rd_sel];
  assign near         = near_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb/tb_ultrasonic_scheduler.sv - randomized scenario bench for ultrasonic_scheduler against a ping-level model
module tb_ultrasonic_scheduler;

  localparam int N  = 4;
  localparam int TT = 5;
  localparam int ET = 400;
  localparam int EM = 5000;
  localparam int GT = 40;
  localparam int NM = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] sensor_mask = '0;
  logic [N-1:0] echo_rx = '0;
  logic [1:0]   rd_sel = '0;
  logic [N-1:0] trig;
  logic         busy;
  logic         sample_valid;
  logic [1:0]   sample_id;
  logic [15:0]  sample_dist;
  logic [15:0]  rd_dist;
  logic [N-1:0] near;

  ultrasonic_scheduler #(
    .N_SENSORS    (N),
    .TRIG_TICKS   (TT),
    .ECHO_TIMEOUT (ET),
    .ECHO_MAX     (EM),
    .GAP_TICKS    (GT),
    .NEAR_MM      (NM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sensor_mask  (sensor_mask),
    .echo_rx      (echo_rx),
    .trig         (trig),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_id    (sample_id),
    .sample_dist  (sample_dist),
    .rd_sel       (rd_sel),
    .rd_dist      (rd_dist),
    .near         (near)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    int len;
    bit pre;
  } ping_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    onehot_bad = 0;
  ping_t plan_q[$];
  int    t_ch[$];
  int    t_start[$];
  int    t_end[$];
  int    s_id[$];
  int    s_dist[$];
  int    s_cyc[$];
  int    exp_ram[N];
  int    last_id;
  logic [N-1:0] mon_prev = '0;
  logic [N-1:0] rsp_prev = '0;

  function automatic int next_ch(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int exp_dist(input int len);
    if (len <= 0 || len >= EM) return 16'hFFFF;
    return (len * 7) / 2048;
  endfunction

  function automatic int ch_of(input logic [N-1:0] t);
    for (int c = 0; c < N; c++) if (t[c]) return c;
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (trig != '0 && mon_prev == '0) begin
      t_ch.push_back(ch_of(trig));
      t_start.push_back(cyc);
    end
    if (trig == '0 && mon_prev != '0) t_end.push_back(cyc);
    if ($countones(trig) > 1) onehot_bad++;
    if (sample_valid) begin
      s_id.push_back(int'(sample_id));
      s_dist.push_back(int'(sample_dist));
      s_cyc.push_back(cyc);
    end
    mon_prev = trig;
  end

  // Echo responder: plays the next planned echo for every trigger pulse it sees.
  initial begin : responder
    ping_t p;
    int    ch;
    int    n;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || trig == '0 || rsp_prev != '0) begin
        rsp_prev = trig;
        continue;
      end
      rsp_prev = trig;
      ch = ch_of(trig);
      if (plan_q.size() > 0) p = plan_q.pop_front();
      else begin
        p.delay = 0; p.len = 0; p.pre = 1'b0;
      end
      if (p.pre) echo_rx[ch] = 1'b1;
      n = 0;
      while (trig != '0 && n < 10000) begin
        @(negedge clk);
        n++;
      end
      rsp_prev = trig;
      repeat (p.delay) @(negedge clk);
      if (p.pre) begin
        echo_rx[ch] = 1'b0;
        repeat (4) @(negedge clk);
      end
      if (p.len > 0) begin
        echo_rx[ch] = 1'b1;
        repeat (p.len) @(negedge clk);
        echo_rx[ch] = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    plan_q.delete(); t_ch.delete(); t_start.delete(); t_end.delete();
    s_id.delete(); s_dist.delete(); s_cyc.delete();
  endtask

  task automatic wait_samples(input int n, input int budget, output bit ok);
    int c = 0;
    while (s_id.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (s_id.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (trig !== '0) begin bad++; $display("FAIL reset_trig got=%b want=0", trig); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sample_valid); end
    total++; if (sample_id !== 2'd0 || sample_dist !== 16'd0) begin
      bad++; $display("FAIL reset_sample got id=%0d dist=%0d want 0/0", sample_id, sample_dist);
    end
    total++; if (near !== '0) begin bad++; $display("FAIL reset_near got=%b want=0", near); end
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c); #1;
      total++; if (rd_dist !== 16'hFFFF) begin bad++; $display("FAIL reset_ram ch%0d got=%h want=ffff", c, rd_dist); end
      exp_ram[c] = 16'hFFFF;
    end
    last_id = N - 1;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy got=%b want=0", busy); end
  endtask

  task automatic test_rotation();
    int    lens[5];
    int    exp_ch[5];
    int    lst;
    bit    ok;
    bit    ok2;
    clear_logs();
    lens[0] = 2926;
    for (int i = 1; i < 5; i++) lens[i] = $urandom_range(300, 4900);
    for (int i = 0; i < 5; i++) plan_q.push_back('{delay: $urandom_range(0, 100), len: lens[i], pre: 1'b0});
    sensor_mask = 4'b1111;
    lst = last_id;
    for (int i = 0; i < 5; i++) begin exp_ch[i] = next_ch(sensor_mask, lst); lst = exp_ch[i]; end
    enable = 1'b1;
    wait_samples(5, 40000, ok);
    enable = 1'b0;
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL rot_timeout samples=%0d want=5 idle=%0d", s_id.size(), ok2); end
    total++; if (t_ch.size() != 5) begin bad++; $display("FAIL rot_trig_count got=%0d want=5", t_ch.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (qget(t_ch, i) != exp_ch[i]) begin bad++; $display("FAIL rot_order[%0d] got=%0d want=%0d", i, qget(t_ch, i), exp_ch[i]); end
      total++; if (qget(t_end, i) - qget(t_start, i) != TT) begin
        bad++; $display("FAIL rot_trig_width[%0d] got=%0d want=%0d", i, qget(t_end, i) - qget(t_start, i), TT);
      end
      total++; if (qget(s_id, i) != exp_ch[i] || qget(s_dist, i) != exp_dist(lens[i])) begin
        bad++; $display("FAIL rot_sample[%0d] got id=%0d dist=%0d want id=%0d dist=%0d", i, qget(s_id, i), qget(s_dist, i), exp_ch[i], exp_dist(lens[i]));
      end
      exp_ram[exp_ch[i]] = exp_dist(lens[i]);
      last_id = exp_ch[i];
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (qget(t_start, i + 1) - qget(t_end, i) < GT) begin
        bad++; $display("FAIL rot_gap[%0d] got=%0d want>=%0d", i, qget(t_start, i + 1) - qget(t_end, i), GT);
      end
    end
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c); #1;
      total++; if (int'(rd_dist) != exp_ram[c]) begin bad++; $display("FAIL rot_ram ch%0d got=%0d want=%0d", c, rd_dist, exp_ram[c]); end
      total++; if (near[c] !== (exp_ram[c] != 16'hFFFF && exp_ram[c] < NM)) begin
        bad++; $display("FAIL rot_near ch%0d got=%b want=%0d", c, near[c], (exp_ram[c] != 16'hFFFF && exp_ram[c] < NM));
      end
    end
  endtask

  task automatic test_reset_in_trig();
    int  n = 0;
    bit  ok;
    bit  ok2;
    clear_logs();
    sensor_mask = 4'b1111;
    enable = 1'b1;
    while (trig == '0 && n < 1000) begin @(negedge clk); n++; end
    total++; if (trig == '0) begin bad++; $display("FAIL rtrig_start got=%b want=nonzero", trig); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if (trig !== '0) begin bad++; $display("FAIL rtrig_drop got=%b want=0", trig); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rtrig_busy got=%b want=0", busy); end
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c); #1;
      total++; if (rd_dist !== 16'hFFFF) begin bad++; $display("FAIL rtrig_ram ch%0d got=%h want=ffff", c, rd_dist); end
      exp_ram[c] = 16'hFFFF;
    end
    repeat (3) @(negedge clk);
    total++; if (s_id.size() != 0) begin bad++; $display("FAIL rtrig_no_sample got=%0d want=0", s_id.size()); end
    last_id = N - 1;
    reset = 1'b1;
    clear_logs();
    wait_samples(1, 3000, ok);
    enable = 1'b0;
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL rtrig_restart_timeout samples=%0d want=1", s_id.size()); end
    total++; if (qget(t_ch, 0) != next_ch(sensor_mask, last_id)) begin
      bad++; $display("FAIL rtrig_first_ch got=%0d want=%0d", qget(t_ch, 0), next_ch(sensor_mask, last_id));
    end
    total++; if (qget(s_dist, 0) != 16'hFFFF) begin bad++; $display("FAIL rtrig_noecho got=%0d want=65535", qget(s_dist, 0)); end
    last_id = next_ch(sensor_mask, last_id);
    exp_ram[last_id] = 16'hFFFF;
  endtask

  task automatic test_enable_drop();
    int n = 0;
    bit ok;
    bit ok2;
    int ch;
    int len;
    clear_logs();
    sensor_mask = 4'b1111;
    ch  = next_ch(sensor_mask, last_id);
    len = $urandom_range(2000, 4000);
    plan_q.push_back('{delay: 10, len: len, pre: 1'b0});
    enable = 1'b1;
    while (echo_rx[ch] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    repeat (200) @(negedge clk);
    enable = 1'b0;
    wait_samples(1, 6000, ok);
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL edrop_timeout samples=%0d busy=%b", s_id.size(), busy); end
    total++; if (qget(s_id, 0) != ch || qget(s_dist, 0) != exp_dist(len)) begin
      bad++; $display("FAIL edrop_sample got id=%0d dist=%0d want id=%0d dist=%0d", qget(s_id, 0), qget(s_dist, 0), ch, exp_dist(len));
    end
    exp_ram[ch] = exp_dist(len);
    last_id = ch;
    repeat (300) @(negedge clk);
    total++; if (t_ch.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL edrop_stopped got trigs=%0d busy=%b want 1/0", t_ch.size(), busy);
    end
    rd_sel = 2'(ch); #1;
    total++; if (int'(rd_dist) != exp_ram[ch]) begin bad++; $display("FAIL edrop_ram got=%0d want=%0d", rd_dist, exp_ram[ch]); end
  endtask

  task automatic test_mask_change();
    int n = 0;
    bit ok;
    bit ok2;
    int e0;
    int e1;
    int l0;
    int l1;
    clear_logs();
    l0 = $urandom_range(500, 4000);
    l1 = $urandom_range(500, 4000);
    plan_q.push_back('{delay: 20, len: l0, pre: 1'b0});
    plan_q.push_back('{delay: 5, len: l1, pre: 1'b0});
    sensor_mask = 4'b0011;
    e0 = next_ch(4'b0011, last_id);
    e1 = next_ch(4'b1000, e0);
    enable = 1'b1;
    while (trig == '0 && n < 1000) begin @(negedge clk); n++; end
    sensor_mask = 4'b1000;
    wait_samples(2, 12000, ok);
    enable = 1'b0;
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL mchg_timeout samples=%0d", s_id.size()); end
    total++; if (qget(t_ch, 0) != e0 || qget(t_ch, 1) != e1) begin
      bad++; $display("FAIL mchg_order got=%0d,%0d want=%0d,%0d", qget(t_ch, 0), qget(t_ch, 1), e0, e1);
    end
    total++; if (qget(s_dist, 0) != exp_dist(l0) || qget(s_dist, 1) != exp_dist(l1)) begin
      bad++; $display("FAIL mchg_dist got=%0d,%0d want=%0d,%0d", qget(s_dist, 0), qget(s_dist, 1), exp_dist(l0), exp_dist(l1));
    end
    exp_ram[e0] = exp_dist(l0);
    exp_ram[e1] = exp_dist(l1);
    last_id = e1;
    for (int c = 0; c < N; c++) begin
      rd_sel = 2'(c); #1;
      total++; if (int'(rd_dist) != exp_ram[c]) begin bad++; $display("FAIL mchg_ram ch%0d got=%0d want=%0d", c, rd_dist, exp_ram[c]); end
    end
  endtask

  task automatic test_timeout_selfwrap();
    bit ok;
    bit ok2;
    int e;
    clear_logs();
    sensor_mask = 4'b0100;
    e = next_ch(sensor_mask, last_id);
    enable = 1'b1;
    wait_samples(2, 3000, ok);
    enable = 1'b0;
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL tmo_timeout samples=%0d", s_id.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if (qget(t_ch, i) != e || qget(s_id, i) != e || qget(s_dist, i) != 16'hFFFF) begin
        bad++; $display("FAIL tmo_sample[%0d] got trig=%0d id=%0d dist=%0d want %0d/%0d/65535", i, qget(t_ch, i), qget(s_id, i), qget(s_dist, i), e, e);
      end
      total++; if (qget(t_end, i) - qget(t_start, i) != TT) begin
        bad++; $display("FAIL tmo_width[%0d] got=%0d want=%0d", i, qget(t_end, i) - qget(t_start, i), TT);
      end
    end
    total++; if (qget(s_cyc, 0) - qget(t_end, 0) != ET) begin
      bad++; $display("FAIL tmo_latency got=%0d want=%0d", qget(s_cyc, 0) - qget(t_end, 0), ET);
    end
    total++; if (qget(t_start, 1) - qget(t_end, 0) < ET + GT) begin
      bad++; $display("FAIL tmo_gap got=%0d want>=%0d", qget(t_start, 1) - qget(t_end, 0), ET + GT);
    end
    exp_ram[e] = 16'hFFFF;
    last_id = e;
    total++; if (near[e] !== 1'b0) begin bad++; $display("FAIL tmo_near got=%b want=0", near[e]); end
  endtask

  task automatic test_echo_limits();
    bit ok;
    bit ok2;
    int e;
    int lens[3];
    clear_logs();
    lens[0] = $urandom_range(1000, 4000);
    lens[1] = EM;
    lens[2] = EM - 1;
    plan_q.push_back('{delay: 30, len: lens[0], pre: 1'b1});
    plan_q.push_back('{delay: 10, len: lens[1], pre: 1'b0});
    plan_q.push_back('{delay: 10, len: lens[2], pre: 1'b0});
    sensor_mask = 4'b0010;
    e = next_ch(sensor_mask, last_id);
    enable = 1'b1;
    wait_samples(3, 25000, ok);
    enable = 1'b0;
    wait_idle(GT + 20, ok2);
    total++; if (!ok || !ok2) begin bad++; $display("FAIL elim_timeout samples=%0d", s_id.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (qget(s_id, i) != e || qget(s_dist, i) != exp_dist(lens[i])) begin
        bad++; $display("FAIL elim_sample[%0d] got id=%0d dist=%0d want id=%0d dist=%0d", i, qget(s_id, i), qget(s_dist, i), e, exp_dist(lens[i]));
      end
    end
    exp_ram[e] = exp_dist(lens[2]);
    last_id = e;
    rd_sel = 2'(e); #1;
    total++; if (int'(rd_dist) != exp_ram[e]) begin bad++; $display("FAIL elim_ram got=%0d want=%0d", rd_dist, exp_ram[e]); end
    total++; if (near[e] !== (exp_ram[e] < NM)) begin bad++; $display("FAIL elim_near got=%b want=%0d", near[e], exp_ram[e] < NM); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_reset_in_trig();
    test_enable_drop();
    test_mask_change();
    test_timeout_selfwrap();
    test_echo_limits();
    total++; if (onehot_bad != 0) begin bad++; $display("FAIL trig_onehot got=%0d cycles with >1 trig want=0", onehot_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
